barrier_ctrl: RTL and testbench
===============================

BARRIER_CTRL -- requirements
Module: barrier_ctrl

Interface
REQ-001 SHALL have parameter NPROC, default 4: number of participating processes (2..8).
REQ-002 SHALL have parameter CNT_W, default 3: width of the arrival counter; SHALL satisfy 2^CNT_W > NPROC.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port arrive  input  NPROC  bit i high = process i requests entry to the barrier.
REQ-006 SHALL have port abort  input  1  cancels the current barrier episode.
REQ-007 SHALL have port arrive_ack  output  NPROC  combinational; bit i high = arrival of process i accepted this cycle.
REQ-008 SHALL have port waiting  output  NPROC  registered bitmap of processes arrived in the current episode.
REQ-009 SHALL have port count  output  CNT_W  registered number of set bits in waiting.
REQ-010 SHALL have port sense  output  1  registered release sense; toggles once per completed episode.
REQ-011 SHALL have port release  output  1  registered; high for exactly one cycle per completed episode.
REQ-012 SHALL have port aborted  output  1  registered; one-cycle pulse after an accepted abort.
REQ-013 SHALL have port dup_err  output  1  registered sticky flag; cleared only by reset.

Function
REQ-014 SHALL implement three states: IDLE (count==0), GATHER (0<count<NPROC) and RELEASE.
REQ-015 arrive_ack[i] SHALL equal arrive[i] & ~waiting[i] & (state!=RELEASE) & ~abort.
REQ-016 A process SHALL be accepted in the same cycle it is acked; it holds arrive until it sees ack and deasserts it on the next cycle.
REQ-017 On each edge, waiting SHALL be set to waiting | arrive_ack, and count SHALL increase by popcount(arrive_ack).
REQ-018 Simultaneous arrivals SHALL all be accepted in the same cycle, with no priority among them.
REQ-019 If count + popcount(arrive_ack) == NPROC, the next edge SHALL enter RELEASE, set waiting to all ones, set count to NPROC and toggle sense.
REQ-020 In RELEASE, release SHALL be 1 and all acks SHALL be 0; arrive inputs SHALL be stalled, not dropped.
REQ-021 The edge after RELEASE SHALL enter IDLE, with waiting and count cleared and release returning to 0.
REQ-022 Latency from the last arrival to release=1 SHALL be exactly 1 cycle; the earliest next-episode ack SHALL be 2 cycles after the last arrival.
REQ-023 arrive[i] high while waiting[i]==1 outside RELEASE SHALL set dup_err on the next edge; waiting and count SHALL be unaffected.
REQ-024 abort in IDLE or GATHER SHALL clear waiting and count, enter IDLE and pulse aborted on the next edge; sense SHALL be unchanged.
REQ-025 abort SHALL take precedence over arrivals in the same cycle: those arrivals are not acked and not counted.
REQ-026 abort during RELEASE SHALL be ignored: the release completes and aborted stays 0.
REQ-027 sense SHALL wrap 1->0 naturally; count SHALL never exceed NPROC.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, waiting=0, count=0, sense=0, release=0, aborted=0 and dup_err=0, independent of clock.
REQ-029 Reset asserted mid-episode (GATHER or RELEASE) SHALL discard all arrivals without producing a release pulse.
REQ-030 The first edge after rst_n deasserts SHALL behave as normal IDLE operation.

Verification
REQ-031 Processes arrive one at a time at cycles 1, 3, 5 and 7 (NPROC=4) -> count goes 1, 2, 3, 4; release=1 at cycle 8; sense 0->1; count=0 at cycle 9.
REQ-032 arrive=4'b1111 for one cycle -> arrive_ack=4'b1111 in that cycle; release on the next cycle; sense toggles.
REQ-033 Process 0 arrives, then holds arrive[0] one extra cycle -> dup_err=1 after that cycle; count stays 1.
REQ-034 Three processes arrived, then abort together with arrive[3] -> arrive_ack=0; aborted pulses; count=0; sense unchanged; no release.
REQ-035 arrive[0] held high during a RELEASE cycle -> no ack in RELEASE; ack in the following IDLE cycle; count=1 afterwards.
REQ-036 rst_n pulsed low while count=2 -> outputs are 0 immediately; there is no release pulse, and later episodes complete normally.

Source files
------------

// File: rtl/barrier_ctrl.sv
// barrier_ctrl: counting barrier with abort, duplicate detection and sense-reversal release
// Ports:
//   clock, rst_n  - rising-edge clock, asynchronous active-low reset
//   arrive        - per-process barrier entry requests (held until acked)
//   abort         - cancels the current episode (ignored during release)
//   arrive_ack    - combinational per-process acceptance this cycle
//   waiting       - registered bitmap of processes arrived this episode
//   count         - registered popcount of waiting
//   sense         - registered release sense, toggles per completed episode
//   release_o     - registered one-cycle release pulse
//   aborted       - registered one-cycle pulse after an accepted abort
//   dup_err       - sticky flag: a process re-requested while already waiting
module barrier_ctrl #(
    parameter int NPROC = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [NPROC-1:0] arrive,
    input  logic             abort,
    output logic [NPROC-1:0] arrive_ack,
    output logic [NPROC-1:0] waiting,
    output logic [CNT_W-1:0] count,
    output logic             sense,
    output logic             release_o,
    output logic             aborted,
    output logic             dup_err
);
    typedef enum logic [1:0] {IDLE, GATHER, RELEASE} state_t;
    state_t           state_q, state_d;
    logic [NPROC-1:0] waiting_q, waiting_d;
    logic [CNT_W-1:0] count_q, count_d, sum;
    logic             sense_q, sense_d;
    logic             release_q, release_d;
    logic             aborted_q, aborted_d;
    logic             dup_err_q, dup_err_d;
    always_comb begin
        arrive_ack = arrive & ~waiting_q & {NPROC{state_q != RELEASE && !abort}};
        sum = count_q;
        for (int i = 0; i < NPROC; i++) sum = sum + CNT_W'(arrive_ack[i]);
        state_d   = state_q;
        waiting_d = waiting_q;
        count_d   = count_q;
        sense_d   = sense_q;
        release_d = 1'b0;
        aborted_d = 1'b0;
        // waiting is all ones in RELEASE, so held arrives there are stalls, not duplicates
        dup_err_d = dup_err_q | (state_q != RELEASE && |(arrive & waiting_q));
        if (state_q == RELEASE) begin
            state_d   = IDLE;
            waiting_d = '0;
            count_d   = '0;
        end else if (abort) begin
            state_d   = IDLE;
            waiting_d = '0;
            count_d   = '0;
            aborted_d = 1'b1;
        end else if (sum == CNT_W'(NPROC)) begin
            state_d   = RELEASE;
            waiting_d = '1;
            count_d   = CNT_W'(NPROC);
            sense_d   = ~sense_q;
            release_d = 1'b1;
        end else begin
            waiting_d = waiting_q | arrive_ack;
            count_d   = sum;
            state_d   = (sum == '0) ? IDLE : GATHER;
        end
    end
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waiting_q <= '0;
            count_q   <= '0;
            sense_q   <= 1'b0;
            release_q <= 1'b0;
            aborted_q <= 1'b0;
            dup_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waiting_q <= waiting_d;
            count_q   <= count_d;
            sense_q   <= sense_d;
            release_q <= release_d;
            aborted_q <= aborted_d;
            dup_err_q <= dup_err_d;
        end
    end
    assign waiting   = waiting_q;
    assign count     = count_q;
    assign sense     = sense_q;
    assign release_o = release_q;
    assign aborted   = aborted_q;
    assign dup_err   = dup_err_q;
endmodule

// File: tb/tb_barrier_ctrl.sv
// tb_barrier_ctrl: vector table, random reference-model run and reset corner cases for barrier_ctrl
module tb_barrier_ctrl;
    logic       clock = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] arrive = '0;
    logic       abort = 1'b0;
    logic [3:0] arrive_ack, waiting;
    logic [2:0] count;
    logic       sense, release_o, aborted, dup_err;
    int         tests = 0;
    int         fails = 0;

    barrier_ctrl #(.NPROC(4), .CNT_W(3)) dut (
        .clock(clock), .rst_n(rst_n), .arrive(arrive), .abort(abort),
        .arrive_ack(arrive_ack), .waiting(waiting), .count(count), .sense(sense),
        .release_o(release_o), .aborted(aborted), .dup_err(dup_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] arr;
        logic       ab;
        logic [3:0] ack;
        logic [3:0] w;
        logic [2:0] c;
        logic       s, r, a, d;
    } vec_t;
    vec_t tv[22];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [3:0] w, input logic [2:0] c,
                            input logic s, input logic r, input logic a, input logic d);
        chk({tag, ".waiting"}, int'(waiting), int'(w));
        chk({tag, ".count"}, int'(count), int'(c));
        chk({tag, ".sense"}, int'(sense), int'(s));
        chk({tag, ".release"}, int'(release_o), int'(r));
        chk({tag, ".aborted"}, int'(aborted), int'(a));
        chk({tag, ".dup_err"}, int'(dup_err), int'(d));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_regs("reset", 4'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1 rst_n = 1'b1;
    endtask

    logic [3:0] m_wait, m_ack;
    logic       m_rel, m_sense, m_ab, m_dup;

    initial begin
        //            arr      ab    ack      waiting  cnt   s     r     a     d
        tv[0]  = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{4'b0010, 1'b0, 4'b0010, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{4'b0100, 1'b0, 4'b0100, 4'b0111, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{4'b0000, 1'b0, 4'b0000, 4'b0111, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{4'b1000, 1'b0, 4'b1000, 4'b1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{4'b1111, 1'b0, 4'b1111, 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[10] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[11] = '{4'b0001, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[13] = '{4'b0110, 1'b0, 4'b0110, 4'b0111, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[14] = '{4'b1000, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[16] = '{4'b1111, 1'b0, 4'b1111, 4'b1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1};
        tv[17] = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[18] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[19] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[20] = '{4'b1110, 1'b0, 4'b1110, 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[21] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};

        #1 do_reset();
        for (int k = 0; k < 22; k++) begin
            arrive = tv[k].arr;
            abort  = tv[k].ab;
            #1 chk($sformatf("vec%0d.ack", k), int'(arrive_ack), int'(tv[k].ack));
            @(posedge clock);
            #1 chk_regs($sformatf("vec%0d", k), tv[k].w, tv[k].c, tv[k].s, tv[k].r, tv[k].a, tv[k].d);
        end

        // random traffic against a set-based model of the barrier
        arrive = '0;
        abort  = 1'b0;
        do_reset();
        m_wait = '0; m_rel = 1'b0; m_sense = 1'b0; m_ab = 1'b0; m_dup = 1'b0;
        for (int k = 0; k < 400; k++) begin
            arrive = 4'($urandom);
            abort  = ($urandom_range(0, 7) == 0);
            m_ack  = (m_rel || abort) ? 4'b0 : (arrive & ~m_wait);
            #1 chk($sformatf("rnd%0d.ack", k), int'(arrive_ack), int'(m_ack));
            if (!m_rel && (arrive & m_wait) != 0) m_dup = 1'b1;
            m_ab = 1'b0;
            if (m_rel) begin
                m_wait = '0;
                m_rel  = 1'b0;
            end else if (abort) begin
                m_wait = '0;
                m_ab   = 1'b1;
            end else begin
                m_wait = m_wait | m_ack;
                if (m_wait == 4'b1111) begin
                    m_rel   = 1'b1;
                    m_sense = ~m_sense;
                end
            end
            @(posedge clock);
            #1 chk_regs($sformatf("rnd%0d", k), m_wait, 3'($countones(m_wait)), m_sense, m_rel, m_ab, m_dup);
        end

        // asynchronous reset mid-episode, then a clean episode
        arrive = '0;
        abort  = 1'b0;
        do_reset();
        arrive = 4'b0011;
        @(posedge clock);
        #1 chk("mid.count", int'(count), 2);
        arrive = 4'b0000;
        #2 rst_n = 1'b0;
        #1 chk_regs("async", 4'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1 chk("held.release", int'(release_o), 0);
        rst_n  = 1'b1;
        arrive = 4'b1111;
        #1 chk("post.ack", int'(arrive_ack), 15);
        @(posedge clock);
        #1 chk_regs("post", 4'b1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        arrive = 4'b0000;
        @(posedge clock);
        #1 chk_regs("post2", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
